// File: rtl/unsigned_divider_u32.sv
// Restoring shift/subtract unsigned divider: rem_quot = {B % A, B / A}, one quotient bit per clock.
// Optional macro UNSIGNED_DIVIDER_DBZ_EN adds a registered div_by_zero flag.
`timescale 1ns/1ps
module unsigned_divider_u32 #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   rem_quot,
`ifdef UNSIGNED_DIVIDER_DBZ_EN
   output logic                 div_by_zero,
`endif
   output logic                 ready
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] divisor;
   logic             launch;

   // One restoring step: trial-subtract the divisor from the top WIDTH+1 bits, then shift left.
   function automatic logic [2*WIDTH-1:0] restore_step(input logic [2*WIDTH-1:0] rq,
                                                      input logic [WIDTH-1:0]   d);
      logic [WIDTH:0] trial;
      trial = rq[2*WIDTH-1:WIDTH-1] - {1'b0, d};
      if (!trial[WIDTH])
         return {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
      else
         return {rq[2*WIDTH-2:0], 1'b0};
   endfunction

   assign launch = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start)
               state_next = BUSY;
         end
         BUSY: begin
            if (count == LAST)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_quot <= '0;
         count    <= '0;
      end else if (launch) begin
         rem_quot <= {{WIDTH{1'b0}}, B};
         count    <= '0;
      end else if (state == BUSY) begin
         rem_quot <= restore_step(rem_quot, divisor);
         count    <= count + CNT_W'(1);
      end
   end

   // The divisor only matters while BUSY, so it needs no reset.
   always_ff @(posedge clk) begin
      if (launch)
         divisor <= A;
   end

`ifdef UNSIGNED_DIVIDER_DBZ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_by_zero <= 1'b0;
      else if (launch)
         div_by_zero <= (A == '0);
   end
`endif

endmodule

// File: tb/tb_unsigned_divider_u32.sv
// Self-checking bench for unsigned_divider_u32 against a plain-arithmetic division model.
`timescale 1ns/1ps
module tb_unsigned_divider_u32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] A, B;
   logic [63:0] rem_quot;
   logic        ready;
`ifdef UNSIGNED_DIVIDER_DBZ_EN
   logic        div_by_zero;
`endif

   int tests = 0;
   int fails = 0;

   unsigned_divider_u32 #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .A          (A),
      .B          (B),
      .rem_quot   (rem_quot),
`ifdef UNSIGNED_DIVIDER_DBZ_EN
      .div_by_zero(div_by_zero),
`endif
      .ready      (ready)
   );

   always #5 clk = ~clk;

   // Reference: {remainder, quotient}; divide by zero yields all-ones quotient and remainder = dividend.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'd0)
         return {b, 32'hFFFF_FFFF};
      return {b % a, b / a};
   endfunction

   // Drive one start pulse; returns 1 time unit after the start edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
      #2;
      tests++;
      if (rem_quot !== 64'd0) begin fails++; $display("FAIL reset_rem_quot actual=%h required=%h", rem_quot, 64'd0); end
      tests++;
      if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready actual=%b required=1", ready); end
      @(negedge clk);
      rst_n = 1'b1;
      edges(2);
      tests++;
      if (ready !== 1'b1) begin fails++; $display("FAIL idle_ready actual=%b required=1", ready); end
   endtask

   task automatic test_basic();
      logic [63:0] exp, held;
      exp = model(32'd7, 32'd100);
      launch(32'd7, 32'd100);
      tests++;
      if (ready !== 1'b0) begin fails++; $display("FAIL basic_busy actual=%b required=0", ready); end
      edges(31);
      tests++;
      if (ready !== 1'b0) begin fails++; $display("FAIL basic_edge31_busy actual=%b required=0", ready); end
      edges(1);
      tests++;
      if (ready !== 1'b1) begin fails++; $display("FAIL basic_edge32_ready actual=%b required=1", ready); end
      tests++;
      if (rem_quot !== exp || exp !== {32'd2, 32'd14}) begin
         fails++; $display("FAIL basic_result actual=%h required=%h", rem_quot, {32'd2, 32'd14});
      end
      held = exp;
      for (int i = 0; i < 10; i++) begin
         edges(1);
         tests++;
         if (rem_quot !== held || ready !== 1'b1) begin
            fails++; $display("FAIL basic_hold%0d actual=%h/%b required=%h/1", i, rem_quot, ready, held);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 100; i++) begin
         b = $urandom;
         a = ($urandom % 10000) + 1;
         launch(a, b);
         edges(34);
         tests++;
         if (rem_quot[31:0] !== b / a || rem_quot[63:32] !== b % a || ready !== 1'b1) begin
            fails++;
            $display("FAIL random%0d B=%h A=%h actual=%h/%b required=%h/1", i, b, a, rem_quot, ready, {b % a, b / a});
         end
      end
   endtask

   task automatic test_boundaries();
      logic [31:0] as [4] = '{32'd1, 32'd9, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] bs [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFE};
      logic [63:0] want [4] = '{{32'd0, 32'hFFFF_FFFF}, {32'd5, 32'd0}, {32'd0, 32'd1}, {32'hFFFF_FFFE, 32'd0}};
      for (int i = 0; i < 4; i++) begin
         launch(as[i], bs[i]);
         edges(32);
         tests++;
         if (rem_quot !== want[i] || rem_quot !== model(as[i], bs[i]) || ready !== 1'b1) begin
            fails++; $display("FAIL boundary%0d actual=%h/%b required=%h/1", i, rem_quot, ready, want[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      launch(32'd0, 32'h1234);
      edges(32);
      tests++;
      if (rem_quot !== {32'h1234, 32'hFFFF_FFFF} || ready !== 1'b1) begin
         fails++; $display("FAIL div_zero actual=%h/%b required=%h/1", rem_quot, ready, {32'h1234, 32'hFFFF_FFFF});
      end
`ifdef UNSIGNED_DIVIDER_DBZ_EN
      tests++;
      if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag_set actual=%b required=1", div_by_zero); end
      launch(32'd3, 32'd10);
      tests++;
      if (div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_flag_clear actual=%b required=0", div_by_zero); end
      edges(32);
`endif
   endtask

   task automatic test_start_while_busy();
      logic [63:0] exp;
      exp = model(32'd1000, 32'd987654321);
      launch(32'd1000, 32'd987654321);
      edges(4);
      @(negedge clk);
      A = 32'd3; B = 32'd77; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges(27);
      tests++;
      if (rem_quot !== exp || ready !== 1'b1) begin
         fails++; $display("FAIL start_while_busy actual=%h/%b required=%h/1", rem_quot, ready, exp);
      end
      edges(1);
      tests++;
      if (rem_quot !== exp || ready !== 1'b1) begin
         fails++; $display("FAIL start_while_busy_hold actual=%h/%b required=%h/1", rem_quot, ready, exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] exp;
      launch(32'd13, 32'hDEAD_BEEF);
      edges(10);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (rem_quot !== 64'd0 || ready !== 1'b1) begin
         fails++; $display("FAIL reset_mid actual=%h/%b required=%h/1", rem_quot, ready, 64'd0);
      end
`ifdef UNSIGNED_DIVIDER_DBZ_EN
      tests++;
      if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_mid_dbz actual=%b required=0", div_by_zero); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      edges(3);
      tests++;
      if (ready !== 1'b1 || rem_quot !== 64'd0) begin
         fails++; $display("FAIL reset_mid_idle actual=%h/%b required=%h/1", rem_quot, ready, 64'd0);
      end
      exp = model(32'd13, 32'hDEAD_BEEF);
      launch(32'd13, 32'hDEAD_BEEF);
      edges(32);
      tests++;
      if (rem_quot !== exp || ready !== 1'b1) begin
         fails++; $display("FAIL reset_mid_recover actual=%h/%b required=%h/1", rem_quot, ready, exp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_boundaries();
      test_div_zero();
      test_start_while_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
